adma_ram_arbiter: RTL and testbench

Two-requester arbiter that shares the single synchronous system RAM port between the ADMA state machine and the host register/CPU path. It sequences grants round-robin, bounds DMA bursts so the host is never starved, and routes 1-cycle-latency read data back to the requester that issued the read. It sits between the DMA engine, the host interface and the RAM model.

---
 rtl/adma_ram_if.sv | 31 +++
 rtl/adma_ram_arbiter.sv | 65 ++++++
 tb/tb_adma_ram_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/adma_ram_if.sv
// adma_ram_if: DMA, host and RAM signals shared by the RAM arbiter and its neighbours.
interface adma_ram_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
);
  logic              dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata, dma_rdata;
  logic              host_req, host_we, host_gnt, host_rvalid;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata, host_rdata;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_write, ram_read;
  logic [DATA_W-1:0] ram_data_in, ram_data_out;
  modport slave (
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid,
    output ram_address, ram_write, ram_read, ram_data_in,
    input  ram_data_out
  );
  modport master (
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid,
    input  ram_address, ram_write, ram_read, ram_data_in,
    output ram_data_out
  );
endinterface

// File: rtl/adma_ram_arbiter.sv
// adma_ram_arbiter: round-robin, burst-bounded sharing of one RAM port between DMA and host.
module adma_ram_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic     CLK,
  input  logic     RESET,
  adma_ram_if.slave bus
);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {IDLE, OWN_DMA, OWN_HOST} state_t;
  state_t            state;
  logic              last_host, rd_pend, rd_tag;
  logic [CW-1:0]     burst_cnt, cnt_inc;
  logic [DATA_W-1:0] dma_hold, host_hold;
  logic              own_dma, own_host, mine, other, issue, we, at_limit, dma_rv, host_rv;
  assign own_dma  = state == OWN_DMA;
  assign own_host = state == OWN_HOST;
  assign mine     = own_dma ? bus.dma_req : own_host & bus.host_req;
  assign other    = own_dma ? bus.host_req : bus.dma_req;
  assign issue    = mine;
  assign we       = own_dma ? bus.dma_we : bus.host_we;
  assign cnt_inc  = (burst_cnt == CW'(MAX_BURST)) ? burst_cnt : burst_cnt + 1'b1;
  assign at_limit = cnt_inc == CW'(MAX_BURST);
  assign dma_rv   = rd_pend & ~rd_tag;
  assign host_rv  = rd_pend & rd_tag;
  assign bus.dma_gnt     = own_dma;
  assign bus.host_gnt    = own_host;
  assign bus.ram_read    = issue & ~we;
  assign bus.ram_write   = issue & we;
  assign bus.ram_address = own_dma ? bus.dma_addr : own_host ? bus.host_addr : '0;
  assign bus.ram_data_in = own_dma ? bus.dma_wdata : own_host ? bus.host_wdata : '0;
  assign bus.dma_rvalid  = dma_rv;
  assign bus.host_rvalid = host_rv;
  // Returned data passes straight through on the pulse and is held afterwards.
  assign bus.dma_rdata   = dma_rv ? bus.ram_data_out : dma_hold;
  assign bus.host_rdata  = host_rv ? bus.ram_data_out : host_hold;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      last_host <= 1'b1;
      burst_cnt <= '0;
      rd_pend   <= 1'b0;
      rd_tag    <= 1'b0;
      dma_hold  <= '0;
      host_hold <= '0;
    end else begin
      rd_pend <= issue & ~we;
      rd_tag  <= own_host;
      if (dma_rv) dma_hold <= bus.ram_data_out;
      if (host_rv) host_hold <= bus.ram_data_out;
      if (state == IDLE) begin
        if (bus.dma_req && (!bus.host_req || last_host)) state <= OWN_DMA;
        else if (bus.host_req) state <= OWN_HOST;
      end else if (!mine || (other && at_limit)) begin
        state     <= other ? (own_dma ? OWN_HOST : OWN_DMA) : IDLE;
        last_host <= own_host;
        burst_cnt <= '0;
      end else begin
        burst_cnt <= cnt_inc;
      end
    end
  end
endmodule

// File: tb/tb_adma_ram_arbiter.sv
// tb_adma_ram_arbiter: directed table, corner sequences and randomized traffic vs a reference model.
module tb_adma_ram_arbiter;
  localparam int MB = 4;
  logic clk = 1'b0, rst = 1'b1, init_mem = 1'b0;
  always #5 clk = ~clk;
  adma_ram_if #(.ADDR_W(64), .DATA_W(32)) bus ();
  adma_ram_arbiter #(.ADDR_W(64), .DATA_W(32), .MAX_BURST(MB)) dut (.CLK(clk), .RESET(rst), .bus(bus));

  function automatic logic [31:0] init_val(int i);
    return (i == 16) ? 32'hDEADBEEF : 32'hC0DE0000 + 32'(i);
  endfunction

  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else begin
      if (bus.ram_write) ram[bus.ram_address[7:0]] <= bus.ram_data_in;
      if (bus.ram_read) bus.ram_data_out <= ram[bus.ram_address[7:0]];
    end
  end

  int errors = 0, checks = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(string t, logic dg, logic hg, logic rr, logic rw, logic [63:0] a,
                         logic [31:0] wd, logic dv, logic hv, logic [31:0] drd, logic [31:0] hrd);
    chk({t, " dma_gnt"}, bus.dma_gnt, dg);
    chk({t, " host_gnt"}, bus.host_gnt, hg);
    chk({t, " ram_read"}, bus.ram_read, rr);
    chk({t, " ram_write"}, bus.ram_write, rw);
    chk({t, " ram_address"}, bus.ram_address, a);
    chk({t, " ram_data_in"}, bus.ram_data_in, wd);
    chk({t, " dma_rvalid"}, bus.dma_rvalid, dv);
    chk({t, " host_rvalid"}, bus.host_rvalid, hv);
    chk({t, " dma_rdata"}, bus.dma_rdata, drd);
    chk({t, " host_rdata"}, bus.host_rdata, hrd);
  endtask

  task automatic idle_in();
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; init_mem = 1'b1;
    idle_in();
    @(posedge clk); #1;
    init_mem = 1'b0; rst = 1'b0;
  endtask

  typedef struct packed {
    logic [3:0]  din;
    logic [7:0]  daddr;
    logic [31:0] dwd;
    logic [7:0]  haddr;
    logic [31:0] hwd;
    logic [3:0]  eg;
    logic [7:0]  ea;
    logic [31:0] ewd;
    logic [1:0]  ev;
    logic [31:0] drd, hrd;
  } vec_t;
  vec_t tbl [13];

  int m_own, m_n;
  bit m_last_host, m_pend, m_pend_host;
  logic [31:0] m_pend_data, m_hd, m_hh;
  logic [31:0] shadow [256];

  initial begin
    int nw, hseen;
    bit got, iss, d_iss, h_iss;
    // din = {dma_req, dma_we, host_req, host_we}; eg = {dma_gnt, host_gnt, read, write}; ev = {dma_rv, host_rv}
    tbl[0]  = '{4'b1000, 8'h10, 32'h0, 8'h00, 32'h0, 4'b0000, 8'h00, 32'h0, 2'b00, 32'h0, 32'h0};
    tbl[1]  = '{4'b1000, 8'h10, 32'h0, 8'h00, 32'h0, 4'b1010, 8'h10, 32'h0, 2'b00, 32'h0, 32'h0};
    tbl[2]  = '{4'b0000, 8'h00, 32'h0, 8'h00, 32'h0, 4'b1000, 8'h00, 32'h0, 2'b10, 32'hDEADBEEF, 32'h0};
    tbl[3]  = '{4'b0011, 8'h00, 32'h0, 8'h40, 32'h12345678, 4'b0000, 8'h00, 32'h0, 2'b00, 32'hDEADBEEF, 32'h0};
    tbl[4]  = '{4'b0011, 8'h00, 32'h0, 8'h40, 32'h12345678, 4'b0101, 8'h40, 32'h12345678, 2'b00, 32'hDEADBEEF, 32'h0};
    tbl[5]  = '{4'b0010, 8'h00, 32'h0, 8'h40, 32'h0, 4'b0110, 8'h40, 32'h0, 2'b00, 32'hDEADBEEF, 32'h0};
    tbl[6]  = '{4'b0000, 8'h00, 32'h0, 8'h00, 32'h0, 4'b0100, 8'h00, 32'h0, 2'b01, 32'hDEADBEEF, 32'h12345678};
    tbl[7]  = '{4'b1010, 8'h10, 32'h0, 8'h40, 32'h0, 4'b0000, 8'h00, 32'h0, 2'b00, 32'hDEADBEEF, 32'h12345678};
    tbl[8]  = '{4'b1010, 8'h10, 32'h0, 8'h40, 32'h0, 4'b1010, 8'h10, 32'h0, 2'b00, 32'hDEADBEEF, 32'h12345678};
    tbl[9]  = '{4'b0010, 8'h00, 32'h0, 8'h40, 32'h0, 4'b1000, 8'h00, 32'h0, 2'b10, 32'hDEADBEEF, 32'h12345678};
    tbl[10] = '{4'b0010, 8'h00, 32'h0, 8'h40, 32'h0, 4'b0110, 8'h40, 32'h0, 2'b00, 32'hDEADBEEF, 32'h12345678};
    tbl[11] = '{4'b0000, 8'h00, 32'h0, 8'h00, 32'h0, 4'b0100, 8'h00, 32'h0, 2'b01, 32'hDEADBEEF, 32'h12345678};
    tbl[12] = '{4'b0000, 8'h00, 32'h0, 8'h00, 32'h0, 4'b0000, 8'h00, 32'h0, 2'b00, 32'hDEADBEEF, 32'h12345678};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      {bus.dma_req, bus.dma_we, bus.host_req, bus.host_we} = tbl[i].din;
      bus.dma_addr = 64'(tbl[i].daddr); bus.dma_wdata = tbl[i].dwd;
      bus.host_addr = 64'(tbl[i].haddr); bus.host_wdata = tbl[i].hwd;
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), tbl[i].eg[3], tbl[i].eg[2], tbl[i].eg[1], tbl[i].eg[0],
              64'(tbl[i].ea), tbl[i].ewd, tbl[i].ev[1], tbl[i].ev[0], tbl[i].drd, tbl[i].hrd);
      @(posedge clk); #1;
    end

    // DMA read issued in the last slot before the host takes over returns to DMA.
    do_reset();
    bus.dma_req = 1'b1; bus.dma_addr = 64'h5;
    bus.host_req = 1'b1; bus.host_addr = 64'h20;
    got = 1'b0; nw = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      iss = bus.dma_gnt && bus.ram_read;
      if (bus.host_gnt) begin
        got = 1'b1;
        chk("switch dma_rvalid", bus.dma_rvalid, 1'b1);
        chk("switch dma_rdata", bus.dma_rdata, 32'hC0DE0008);
        chk("switch host_rvalid", bus.host_rvalid, 1'b0);
        chk("switch dma reads", 64'(nw), 64'(MB));
      end else if (iss) nw++;
      @(posedge clk); #1;
      if (iss) bus.dma_addr = bus.dma_addr + 64'h1;
    end
    chk("switch host_gnt seen", got, 1'b1);

    // Burst limit with the host waiting.
    do_reset();
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 64'h80; bus.dma_wdata = 32'h1000;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 64'h50; bus.host_wdata = 32'hAAAA5555;
    got = 1'b0; nw = 0;
    for (int c = 0; c < 15 && !got; c++) begin
      @(negedge clk);
      iss = bus.dma_gnt && bus.ram_write;
      if (bus.host_gnt) begin
        got = 1'b1;
        chk("burst host write", bus.ram_write, 1'b1);
        chk("burst host addr", bus.ram_address, 64'h50);
      end else if (iss) nw++;
      @(posedge clk); #1;
      if (iss) begin bus.dma_addr = bus.dma_addr + 64'h1; bus.dma_wdata = bus.dma_wdata + 32'h1; end
    end
    chk("burst dma writes", 64'(nw), 64'(MB));
    chk("burst host_gnt seen", got, 1'b1);

    // No competition: DMA keeps the port well past MAX_BURST.
    do_reset();
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 64'h80;
    nw = 0; hseen = 0;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      iss = bus.dma_gnt && bus.ram_write;
      if (iss) nw++;
      if (bus.host_gnt) hseen++;
      @(posedge clk); #1;
      if (iss) bus.dma_addr = bus.dma_addr + 64'h1;
    end
    chk("stream dma writes", 64'(nw), 64'd20);
    chk("stream host_gnt", 64'(hseen), 64'd0);

    // Asynchronous reset in the middle of a read burst.
    do_reset();
    bus.dma_req = 1'b1; bus.dma_addr = 64'h10;
    bus.host_req = 1'b1; bus.host_addr = 64'h40;
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("prereset ram_read", bus.ram_read, 1'b1);
    rst = 1'b1; #1;
    chk("rst dma_gnt", bus.dma_gnt, 1'b0);
    chk("rst host_gnt", bus.host_gnt, 1'b0);
    chk("rst ram_read", bus.ram_read, 1'b0);
    chk("rst ram_write", bus.ram_write, 1'b0);
    chk("rst dma_rvalid", bus.dma_rvalid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post rst dma_rvalid", bus.dma_rvalid, 1'b0);
    chk("post rst host_rvalid", bus.host_rvalid, 1'b0);
    chk("post rst dma_rdata", bus.dma_rdata, 32'h0);
    chk("post rst idle gnt", {bus.dma_gnt, bus.host_gnt}, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post rst tie dma_gnt", bus.dma_gnt, 1'b1);
    chk("post rst tie host_gnt", bus.host_gnt, 1'b0);
    @(posedge clk); #1;

    // Randomized traffic against a transaction-level reference.
    do_reset();
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    m_own = 0; m_n = 0; m_last_host = 1'b1; m_pend = 1'b0; m_pend_host = 1'b0;
    m_pend_data = '0; m_hd = '0; m_hh = '0;
    d_iss = 1'b0; h_iss = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic dq, hq, mine, other, we, e_dv, e_hv;
      logic [63:0] a;
      logic [31:0] wd;
      if (!bus.dma_req || d_iss) begin
        bus.dma_req = $urandom_range(0, 4) != 0; bus.dma_we = 1'($urandom);
        bus.dma_addr = {32'($urandom), 32'($urandom)}; bus.dma_wdata = 32'($urandom);
      end
      if (!bus.host_req || h_iss) begin
        bus.host_req = $urandom_range(0, 2) == 0; bus.host_we = 1'($urandom);
        bus.host_addr = {32'($urandom), 32'($urandom)}; bus.host_wdata = 32'($urandom);
      end
      @(negedge clk);
      dq = bus.dma_req; hq = bus.host_req;
      mine  = (m_own == 1) ? dq : (m_own == 2) ? hq : 1'b0;
      other = (m_own == 1) ? hq : dq;
      we = (m_own == 1) ? bus.dma_we : bus.host_we;
      a  = (m_own == 1) ? bus.dma_addr : (m_own == 2) ? bus.host_addr : 64'h0;
      wd = (m_own == 1) ? bus.dma_wdata : (m_own == 2) ? bus.host_wdata : 32'h0;
      e_dv = m_pend && !m_pend_host;
      e_hv = m_pend && m_pend_host;
      if (e_dv) m_hd = m_pend_data;
      if (e_hv) m_hh = m_pend_data;
      chk_all($sformatf("rnd%0d", c), m_own == 1, m_own == 2, mine && !we, mine && we, a, wd,
              e_dv, e_hv, m_hd, m_hh);
      d_iss = (m_own == 1) && dq;
      h_iss = (m_own == 2) && hq;
      if (mine && we) shadow[a[7:0]] = wd;
      m_pend = mine && !we;
      m_pend_host = m_own == 2;
      if (m_pend) m_pend_data = shadow[a[7:0]];
      if (m_own == 0) begin
        if (dq && (!hq || m_last_host)) m_own = 1;
        else if (hq) m_own = 2;
      end else if (!mine || (other && m_n + 1 >= MB)) begin
        m_last_host = m_own == 2;
        m_own = other ? 3 - m_own : 0;
        m_n = 0;
      end else m_n++;
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
